// File: rtl/s2p_defs.sv
// Shared definitions for the serial link (receiver and transmitter):
// FSM encodings, byte width and default sync/idle bytes.
package s2p_defs;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE  = 8'hBC;
    localparam logic [BYTE_W-1:0] DEF_IDLE_BYTE  = 8'h7C;
    localparam int                DEF_SYNC_COUNT = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial-line / byte-datapath bundle of the receiver. The slave side is the
// receiver; dbg_state exposes its FSM state for checkers.
interface serial_to_parallel_rx_if;
    import s2p_defs::*;

    logic              S;
    logic [BYTE_W-1:0] DATA_OUT;
    logic              VALID;
    logic              ACTIVE;
    logic [1:0]        dbg_state;

    // VALID is a one-cycle strobe with no back-pressure: DATA_OUT is new on
    // every cycle VALID is high and holds its value otherwise.
    modport master (output S, input DATA_OUT, input VALID, input ACTIVE, input dbg_state);
    modport slave  (input S, output DATA_OUT, output VALID, output ACTIVE, output dbg_state);
endinterface

// File: rtl/s2p_shift8.sv
// 8-bit MSB-first shift register; o_sr_next is the value the register takes
// on the coming edge, so decisions can be made on the bit being sampled now.
module s2p_shift8
    import s2p_defs::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bit,
    output logic [BYTE_W-1:0] o_sr_next
);

    logic [BYTE_W-1:0] r_sr;
    logic [BYTE_W-1:0] w_sr_next;

    assign w_sr_next = {r_sr[BYTE_W-2:0], i_bit};
    assign o_sr_next = w_sr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: hunts for SYNC_BYTE, confirms SYNC_COUNT aligned
// sync bytes, then strobes out every aligned byte. Optional: S2P_IDLE_FILTER_EN.
module serial_to_parallel_rx
    import s2p_defs::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int                SYNC_COUNT = DEF_SYNC_COUNT,
    parameter logic [BYTE_W-1:0] IDLE_BYTE  = DEF_IDLE_BYTE
)
(
    input  logic C,
    input  logic R,
    serial_to_parallel_rx_if.slave rx_bus
);

    localparam logic [3:0] SYNC_CNT4 = 4'(SYNC_COUNT);
`ifdef S2P_IDLE_FILTER_EN
    localparam logic IDLE_FILTER = 1'b1;
`else
    localparam logic IDLE_FILTER = 1'b0;
`endif

    state_t            r_state, w_state_n;
    logic [2:0]        r_bitcnt, w_bitcnt_n;
    logic [3:0]        r_bc_cnt, w_bc_n, w_bc_inc;
    logic [BYTE_W-1:0] r_data, w_data_n;
    logic              r_valid, w_valid_n;
    logic [BYTE_W-1:0] w_sr_next;
    logic              w_is_sync, w_is_idle, w_boundary;

    s2p_shift8 u_shift (
        .i_clk     (C),
        .i_rst_n   (R),
        .i_bit     (rx_bus.S),
        .o_sr_next (w_sr_next)
    );

    assign w_is_sync  = (w_sr_next == SYNC_BYTE);
    assign w_is_idle  = (w_sr_next == IDLE_BYTE);
    assign w_boundary = (r_bitcnt == 3'd7);
    assign w_bc_inc   = (r_bc_cnt == SYNC_CNT4) ? r_bc_cnt : r_bc_cnt + 4'd1;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state  <= ST_SEARCH;
            r_bitcnt <= 3'd0;
            r_bc_cnt <= 4'd0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_bitcnt <= w_bitcnt_n;
            r_bc_cnt <= w_bc_n;
            r_data   <= w_data_n;
            r_valid  <= w_valid_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_bitcnt_n = r_bitcnt;
        w_bc_n     = r_bc_cnt;
        w_data_n   = r_data;
        w_valid_n  = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                // The sync byte just completed defines the byte phase.
                if (w_is_sync) begin
                    w_bitcnt_n = 3'd0;
                    w_bc_n     = 4'd1;
                    w_state_n  = (SYNC_CNT4 == 4'd1) ? ST_ACTIVE : ST_SYNC;
                end
            end
            ST_SYNC: begin
                w_bitcnt_n = r_bitcnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_sync) begin
                        w_bc_n = w_bc_inc;
                        if (w_bc_inc == SYNC_CNT4) begin
                            w_state_n = ST_ACTIVE;
                        end
                    end else begin
                        w_bc_n    = 4'd0;
                        w_state_n = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                w_bitcnt_n = r_bitcnt + 3'd1;
                if (w_boundary && !(IDLE_FILTER && w_is_idle)) begin
                    w_data_n  = w_sr_next;
                    w_valid_n = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_SEARCH;
            end
        endcase
    end

    assign rx_bus.DATA_OUT  = r_data;
    assign rx_bus.VALID     = r_valid;
    assign rx_bus.ACTIVE    = (r_state == ST_ACTIVE);
    assign rx_bus.dbg_state = r_state;

endmodule
